serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Parametrised multi-cycle unsigned subtractor. Computes diff = a - b - bin over WIDTH bits, BITS_PER_CYCLE bits per clock, LSB slice first.
- The borrow is carried between slices in a register.
- Successor to the single-bit combinational full subtractor. Used where a wide subtract can be traded for latency, e.g. in datapaths with area limits or in serial arithmetic.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be ≥1.
- BITS_PER_CYCLE, 1, bits processed per clock. Must divide WIDTH exactly; an elaboration-time check enforces this.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the block is not busy.
- a  input  WIDTH  minuend, captured on accepted start.
- b  input  WIDTH  subtrahend, captured on accepted start.
- bin  input  1  borrow-in, captured on accepted start.
- busy  output  1  high while slices are being processed.
- done  output  1  one-cycle pulse: result valid.
- diff  output  WIDTH  result, (a - b - bin) mod 2^WIDTH.
- bout  output  1  final borrow; 1 iff a < b + bin (unsigned).

Behaviour:
- Reset: rst is sampled on the clk edge. State goes to IDLE, and busy=0, done=0, diff=0, bout=0. The internal operand shift registers, borrow register and slice counter are all cleared.
- Reset mid-operation aborts the operation immediately. done is not pulsed and no partial result is exposed.
- NSLICE = WIDTH/BITS_PER_CYCLE. The counter is $clog2(NSLICE+1) bits wide.
- State IDLE: start=1 at edge k latches a, b and bin. The borrow register is loaded with bin, the counter is cleared, and the state goes to RUN. busy=1 from edge k.
- State RUN: on each edge, one slice is processed:
  - The lowest BITS_PER_CYCLE bits of the a/b shift registers pass through a chain of 1-bit cells.
  - The slice difference is shifted into the top of the result register (result fills MSB-first by shift, LSB-first in arithmetic order).
  - The borrow register takes the chain borrow-out.
  - The counter increments.
- RUN → DONE on the edge that processes slice NSLICE-1, which is edge k+NSLICE.
  - On that edge: diff is final, bout equals the borrow register, done=1 and busy=0.
  - Latency from start sample to done is therefore NSLICE clocks.
- State DONE lasts one cycle. done=1 in this cycle only.
  - start=1 in DONE is accepted exactly as in IDLE. Back-to-back operations have no bubble.
  - Otherwise the state goes to IDLE.
- While in RUN, start is ignored. The a, b and bin ports are don't-care.
- diff and bout hold their last result until the next completion or reset. They do not change during RUN; an internal result register is copied on completion.
- WIDTH=BITS_PER_CYCLE (NSLICE=1): the result appears on the edge after start sampling. done is then high the cycle after start.
- Cell equations:
  - d = x ^ y ^ bi
  - bo = (~x & y) | (~(x ^ y) & bi)

Decomposition:
- Shared package serial_arith_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - the NSLICE computation helper.
- Sub-module full_subtractor_cell: the 1-bit cell with ports x, y, bi, d, bo. It is instantiated BITS_PER_CYCLE times in a generate chain; this is the only sub-module.
- The control FSM, counter and shift registers live in serial_subtractor.

Test Plan:
- WIDTH=1, BITS_PER_CYCLE=1, all 8 {a,b,bin} combinations. Expect {bout,diff} = 00,11,11,10,01,00,00,11 for i=0..7. done must be 1 cycle after start each time.
- WIDTH=8, BITS_PER_CYCLE=1, a=0x5A, b=0x23, bin=0. Expect diff=0x37, bout=0. done pulses exactly 8 clocks after start and lasts one cycle; busy is high for those 8 cycles.
- WIDTH=8, BITS_PER_CYCLE=1, underflow/borrow cases:
  - a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1.
  - a=0x80, b=0x80, bin=1 → diff=0xFF, bout=1.
- WIDTH=8, BITS_PER_CYCLE=4, a=0xF0, b=0x0F, bin=1. Expect diff=0xE0, bout=0, done after 2 clocks. Then assert start in the done cycle with a=0x01, b=0x02 → next done 2 clocks later with diff=0xFF, bout=1.
- WIDTH=8, BITS_PER_CYCLE=1: pulse start again, with different operands, at cycle 3 of a run. The second start must be ignored and the original result delivered. Assert rst at cycle 5 of a later run: busy=0, done never pulses, and diff=0x00, bout=0 after reset.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the serial arithmetic blocks: controller state
// encoding and the slice-count helper.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Number of slices needed to cover a word of the given width.
   function automatic int calc_nslice(input int width, input int bits_per_cycle);
      return width / bits_per_cycle;
   endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = x - y - bi, bo set when the bit underflows.
module full_subtractor_cell (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor: diff = a - b - bin, processed
// BITS_PER_CYCLE bits per clock, least significant slice first.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; diff/bout hold the last result
// ST_RUN  | one slice per clock through the cell chain; start ignored
// ST_DONE | single cycle, result valid; start accepted as in ST_IDLE
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int NSLICE = calc_nslice(WIDTH, BITS_PER_CYCLE);
   localparam int CNT_W  = $clog2(NSLICE + 1);
   localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

   if (WIDTH < 1 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_param_check
      $error("serial_subtractor: BITS_PER_CYCLE must be >= 1 and divide WIDTH exactly");
   end

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               borrow_q, borrow_d;
   logic               bout_q, bout_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [BITS_PER_CYCLE-1:0] slice_diff;
   logic [BITS_PER_CYCLE:0]   chain_b;
   logic [WIDTH-1:0]          res_shift;

   assign chain_b[0] = borrow_q;

   for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_cell
      full_subtractor_cell u_cell (
         .x  (a_q[i]),
         .y  (b_q[i]),
         .bi (chain_b[i]),
         .d  (slice_diff[i]),
         .bo (chain_b[i+1])
      );
   end

   // New slice enters at the top so the word ends up in arithmetic order
   // once every slice has been shifted in.
   assign res_shift = (res_q >> BITS_PER_CYCLE) | (WIDTH'(slice_diff) << (WIDTH - BITS_PER_CYCLE));

   // Next-state, operand shifting and result capture.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      bout_d   = bout_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d  = ST_RUN;
               a_d      = a;
               b_d      = b;
               borrow_d = bin;
               cnt_d    = '0;
               res_d    = '0;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_RUN: begin
            a_d      = a_q >> BITS_PER_CYCLE;
            b_d      = b_q >> BITS_PER_CYCLE;
            res_d    = res_shift;
            borrow_d = chain_b[BITS_PER_CYCLE];
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_SLICE) begin
               state_d = ST_DONE;
               diff_d  = res_shift;
               bout_d  = chain_b[BITS_PER_CYCLE];
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset drops any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         bout_q   <= bout_d;
         cnt_q    <= cnt_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);
   assign diff = diff_q;
   assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor in three configurations (1/1, 8/1, 8/4).
// Stimulus pushes expected completions and per-cycle state probes; one
// monitor process checks them against the DUT outputs.
module tb_serial_subtractor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [2:0] rst_s;
   logic [2:0] start_s;
   logic [2:0] bin_s;
   logic [7:0] a_s [3];
   logic [7:0] b_s [3];
   wire  [2:0] busy_s;
   wire  [2:0] done_s;
   wire  [2:0] bout_s;
   wire  [7:0] diff_s [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int W = (g == 0) ? 1 : 8;
      localparam int B = (g == 2) ? 4 : 1;
      wire [W-1:0] diff_w;
      serial_subtractor #(.WIDTH(W), .BITS_PER_CYCLE(B)) u_dut (
         .clk   (clk),
         .rst   (rst_s[g]),
         .start (start_s[g]),
         .a     (a_s[g][W-1:0]),
         .b     (b_s[g][W-1:0]),
         .bin   (bin_s[g]),
         .busy  (busy_s[g]),
         .done  (done_s[g]),
         .diff  (diff_w),
         .bout  (bout_s[g])
      );
      assign diff_s[g] = 8'(diff_w);
   end

   typedef struct {
      int         inst;
      logic [7:0] diff;
      logic       bout;
      int         due;
   } exp_t;

   typedef struct {
      int         inst;
      int         at;
      int         tag;
      logic       busy;
      logic       done;
      logic [7:0] diff;
      logic       bout;
   } probe_t;

   exp_t   sb_q [$];
   probe_t probe_q [$];
   exp_t   mon_e;
   probe_t mon_p;

   int errors = 0;
   int checks = 0;
   logic mon_en = 1'b0;

   logic [7:0] held_diff [3];
   logic [2:0] held_bout;

   function automatic int ns_of(input int i);
      return (i == 0) ? 1 : ((i == 1) ? 8 : 2);
   endfunction

   function automatic int w_of(input int i);
      return (i == 0) ? 1 : 8;
   endfunction

   // Reference: plain integer subtraction, wrapped to the word width.
   function automatic void ref_sub(input int w, input logic [7:0] av, input logic [7:0] bv,
                                   input logic bi, output logic [7:0] d, output logic bo);
      int mask;
      int r;
      mask = (1 << w) - 1;
      r    = (int'(av) & mask) - (int'(bv) & mask) - int'(bi);
      bo   = (r < 0);
      d    = 8'(r & mask);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic probe(input int i, input int tag, input logic bsy, input logic dn);
      probe_t p;
      p.inst = i;
      p.at   = cyc;
      p.tag  = tag;
      p.busy = bsy;
      p.done = dn;
      p.diff = held_diff[i];
      p.bout = held_bout[i];
      probe_q.push_back(p);
   endtask

   task automatic idle(input int i, input int n, input int tag);
      for (int j = 0; j < n; j++) begin
         tick();
         probe(i, tag, 1'b0, 1'b0);
      end
   endtask

   // Issue one operation. poke_at / rst_at name a run cycle at which a
   // stray start or a reset is applied (-1 for none).
   task automatic run_op(input int i, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                         input int tag, input int poke_at, input int rst_at);
      logic [7:0] rd;
      logic       rb;
      int         k;
      int         ns;
      exp_t       e;
      ns = ns_of(i);
      ref_sub(w_of(i), av, bv, bi, rd, rb);
      a_s[i]     = av;
      b_s[i]     = bv;
      bin_s[i]   = bi;
      start_s[i] = 1'b1;
      tick();
      start_s[i] = 1'b0;
      k = cyc;
      e.inst = i;
      e.diff = rd;
      e.bout = rb;
      e.due  = k + ns;
      sb_q.push_back(e);
      probe(i, tag, 1'b1, 1'b0);
      for (int j = 1; j < ns; j++) begin
         if (j == poke_at) begin
            start_s[i] = 1'b1;
            a_s[i]     = ~av;
            b_s[i]     = av;
            bin_s[i]   = ~bi;
         end
         if (j == rst_at) rst_s[i] = 1'b1;
         tick();
         start_s[i] = 1'b0;
         if (j == rst_at) begin
            rst_s[i] = 1'b0;
            sb_q.delete();
            held_diff[i] = 8'h00;
            held_bout[i] = 1'b0;
            probe(i, tag, 1'b0, 1'b0);
            return;
         end
         probe(i, tag, 1'b1, 1'b0);
      end
      tick();
      held_diff[i] = rd;
      held_bout[i] = rb;
      probe(i, tag, 1'b0, 1'b1);
   endtask

   // Monitor: match completions against the scoreboard, then apply probes.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < 3; i++) begin
            if (done_s[i] === 1'b1) begin
               checks++;
               if (sb_q.size() == 0 || sb_q[0].inst != i) begin
                  errors++;
                  $display("FAIL unexpected_done inst=%0d cyc=%0d got done=1 required done=0", i, cyc);
               end else begin
                  mon_e = sb_q.pop_front();
                  if (diff_s[i] !== mon_e.diff || bout_s[i] !== mon_e.bout || cyc != mon_e.due) begin
                     errors++;
                     $display("FAIL result inst=%0d got diff=%h bout=%b cyc=%0d required diff=%h bout=%b cyc=%0d",
                              i, diff_s[i], bout_s[i], cyc, mon_e.diff, mon_e.bout, mon_e.due);
                  end
               end
            end
         end
         if (sb_q.size() != 0 && cyc > sb_q[0].due) begin
            checks++;
            errors++;
            mon_e = sb_q.pop_front();
            $display("FAIL done_timeout inst=%0d cyc=%0d got no done required done at cyc=%0d",
                     mon_e.inst, cyc, mon_e.due);
         end
         while (probe_q.size() != 0 && probe_q[0].at <= cyc) begin
            mon_p = probe_q.pop_front();
            checks++;
            if (busy_s[mon_p.inst] !== mon_p.busy || done_s[mon_p.inst] !== mon_p.done ||
                diff_s[mon_p.inst] !== mon_p.diff || bout_s[mon_p.inst] !== mon_p.bout) begin
               errors++;
               $display("FAIL state_probe test=%0d inst=%0d cyc=%0d got busy=%b done=%b diff=%h bout=%b required busy=%b done=%b diff=%h bout=%b",
                        mon_p.tag, mon_p.inst, cyc,
                        busy_s[mon_p.inst], done_s[mon_p.inst], diff_s[mon_p.inst], bout_s[mon_p.inst],
                        mon_p.busy, mon_p.done, mon_p.diff, mon_p.bout);
            end
         end
      end
   end

   initial begin
      logic [2:0] t;
      int         inst;
      int         poke;
      rst_s     = 3'b111;
      start_s   = 3'b000;
      bin_s     = 3'b000;
      held_bout = 3'b000;
      for (int i = 0; i < 3; i++) begin
         a_s[i]       = 8'h00;
         b_s[i]       = 8'h00;
         held_diff[i] = 8'h00;
      end
      repeat (2) tick();
      rst_s  = 3'b000;
      mon_en = 1'b1;
      for (int i = 0; i < 3; i++) probe(i, 0, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) probe(i, 0, 1'b0, 1'b0);

      // 1-bit word: every {a,b,bin} combination, back to back and with gaps.
      for (int v = 0; v < 8; v++) begin
         t = 3'(v);
         run_op(0, {7'd0, t[2]}, {7'd0, t[1]}, t[0], 1, -1, -1);
         if (v % 2 == 1) idle(0, 1, 1);
      end

      // 8-bit word, one bit per clock: nominal and borrow-out cases.
      run_op(1, 8'h5A, 8'h23, 1'b0, 2, -1, -1);
      idle(1, 2, 2);
      run_op(1, 8'h00, 8'h01, 1'b0, 3, -1, -1);
      idle(1, 1, 3);
      run_op(1, 8'h80, 8'h80, 1'b1, 3, -1, -1);
      idle(1, 1, 3);

      // Stray start mid-run is ignored; reset mid-run aborts and clears.
      run_op(1, 8'h3C, 8'h11, 1'b0, 4, 3, -1);
      idle(1, 2, 4);
      run_op(1, 8'h77, 8'h12, 1'b1, 5, -1, 5);
      idle(1, 12, 5);

      // Nibble-serial, with the second start issued in the done cycle.
      run_op(2, 8'hF0, 8'h0F, 1'b1, 6, -1, -1);
      run_op(2, 8'h01, 8'h02, 1'b0, 6, -1, -1);
      idle(2, 2, 6);

      // Random operations across all three configurations.
      for (int n = 0; n < 60; n++) begin
         inst = int'($urandom_range(2, 0));
         poke = -1;
         if (inst == 1 && $urandom_range(3, 0) == 0) poke = int'($urandom_range(7, 1));
         run_op(inst, 8'($urandom), 8'($urandom), 1'($urandom), 7, poke, -1);
         idle(inst, int'($urandom_range(2, 0)), 7);
      end

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
